// File: rtl/n2w_buffer_ctrl.sv
// Purpose: packs narrow W beats into wide RAM words and replays committed words on a wide stream.
// Latency: a completing beat at T commits at T+1 (ram_rd_en high), and m_valid rises at T+2.
// Backpressure: s_ready = !full from the registered count; m_ready stalls read issue and holds the output.
// Ports: s_* narrow input stream, m_* wide output stream (m_data straight from the RAM),
//        ram_wr_* / ram_rd_* drive a wide-by-wide dual-port RAM, level = committed entries.
module n2w_buffer_ctrl #(
  parameter int NARROW_WIDTH = 32,
  parameter int WIDE_WIDTH   = 64,
  parameter int RATIO        = WIDE_WIDTH / NARROW_WIDTH,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NARROW_WIDTH-1:0]   s_data,
  input  logic [NARROW_WIDTH/8-1:0] s_strb,
  input  logic                      s_last,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [WIDE_WIDTH-1:0]     m_data,
  output logic [WIDE_WIDTH/8-1:0]   m_strb,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
  output logic [WIDE_WIDTH-1:0]     ram_wr_data,
  output logic [WIDE_WIDTH/8-1:0]   ram_wr_en,
  output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
  output logic                      ram_rd_en,
  input  logic [WIDE_WIDTH-1:0]     ram_rd_data,
  output logic [ADDR_WIDTH:0]       level
);

  localparam int NB     = NARROW_WIDTH / 8;
  localparam int WB     = WIDE_WIDTH / 8;
  localparam int LANE_W = $clog2(RATIO);

  localparam logic [ADDR_WIDTH:0] FULL_CNT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(RATIO - 1);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [LANE_W-1:0]     lane;
  logic [ADDR_WIDTH:0]   count;

  // Per-entry strobe and last flags live in flops beside the RAM.
  logic [WB-1:0] strb_mem [DEPTH];
  logic          last_mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          issue;
  logic [WB-1:0] lane_strb;

  // The word being filled is not counted, so count < DEPTH also means its slot is free.
  assign s_ready = (count < FULL_CNT);
  assign accept  = s_valid && s_ready;
  assign commit  = accept && (s_last || (lane == LAST_LANE));

  // Issue only when the output register is empty or draining this cycle,
  // so m_data/m_strb/m_last cannot move while stalled.
  assign issue = (count != '0) && (!m_valid || m_ready);

  assign lane_strb = WB'(s_strb) << (int'(lane) * NB);

  assign ram_wr_addr = wptr;
  assign ram_wr_data = {RATIO{s_data}};
  assign ram_wr_en   = accept ? lane_strb : '0;
  assign ram_rd_addr = rptr;
  assign ram_rd_en   = issue;
  assign m_data      = ram_rd_data;
  assign level       = count;

  // Write pointer and lane position within the word being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      lane <= '0;
    end else if (accept) begin
      if (commit) begin
        wptr <= wptr + ADDR_WIDTH'(1);
        lane <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
      end
    end
  end

  // Side arrays need no reset: lane 0 overwrites the strobe and every commit
  // writes the last flag before the entry can be counted and read.
  always_ff @(posedge clk) begin
    if (accept) begin
      strb_mem[wptr] <= (lane == '0) ? lane_strb : (strb_mem[wptr] | lane_strb);
      if (commit) begin
        last_mem[wptr] <= s_last;
      end
    end
  end

  // Read side: the RAM registers the word on issue; strobe/last are registered
  // alongside so all three present together one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr    <= '0;
      m_valid <= 1'b0;
      m_strb  <= '0;
      m_last  <= 1'b0;
    end else if (issue) begin
      rptr    <= rptr + ADDR_WIDTH'(1);
      m_strb  <= strb_mem[rptr];
      m_last  <= last_mem[rptr];
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Committed-entry count; commit and issue in the same cycle cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({commit, issue})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_n2w_buffer_ctrl.sv
module tb_n2w_buffer_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_strb;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  ram_wr_addr;
  logic [63:0] ram_wr_data;
  logic [7:0]  ram_wr_en;
  logic [3:0]  ram_rd_addr;
  logic        ram_rd_en;
  logic [63:0] ram_rd_data;
  logic [4:0]  level;

  n2w_buffer_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_strb      (s_strb),
    .s_last      (s_last),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_strb      (m_strb),
    .m_last      (m_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_data (ram_rd_data),
    .level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-enable RAM with registered read that holds while ram_rd_en is low.
  logic [63:0] ram [16];
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++)
      if (ram_wr_en[b]) ram[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
  end

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int rdy_drops = 0;
  logic sb_en = 1'b0;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic        s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_strb;
    logic        s_last;
    logic        m_ready;
    logic        e_s_ready;
    logic [7:0]  e_wr_en;
    logic [3:0]  e_wr_addr;
    logic        e_rd_en;
    logic [3:0]  e_rd_addr;
    logic        e_m_valid;
    logic [7:0]  e_m_strb;
    logic        e_m_last;
    logic [63:0] e_m_data;
    logic [4:0]  e_level;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++)
      if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] st, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_strb = st; s_last = l;
    #1;
    if (!s_ready) rdy_drops++;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_beat timeout actual=s_ready_low expected=s_ready_high");
    end else begin
      @(posedge clk);
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] lo, input logic [31:0] hi, input logic l);
    exp_q.push_back('{last: l, data: {hi, lo}});
    send_beat(lo, 4'hF, 1'b0);
    send_beat(hi, 4'hF, l);
  endtask

  task automatic drain(input int exp_hs, input int base);
    int n;
    n = 0;
    @(negedge clk);
    m_ready = 1'b1;
    #3;
    while ((exp_q.size() != 0 || m_valid) && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_done", 64'(n < 300), 64'(1));
    chk("drain_words", 64'(hs_count - base), 64'(exp_hs));
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; sb_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard: checks every output handshake against the expected queue and
  // that the output is frozen across a stalled cycle.
  initial begin : monitor
    logic        stall_prev;
    logic [63:0] held_d;
    logic [7:0]  held_s;
    logic        held_l;
    exp_t        e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (sb_en && rst_n) begin
        if (stall_prev) begin
          checks++;
          if (!m_valid || m_data !== held_d || m_strb !== held_s || m_last !== held_l) begin
            errors++;
            $display("FAIL stall_hold actual=v%0b d%0h s%0h l%0b expected=v1 d%0h s%0h l%0b",
                     m_valid, m_data, m_strb, m_last, held_d, held_s, held_l);
          end
        end
        if (m_valid && m_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%0h expected=none", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", m_data, e.data);
            chk("out_strb", 64'(m_strb), 64'(8'hFF));
            chk("out_last", 64'(m_last), 64'(e.last));
          end
        end
        stall_prev = m_valid && !m_ready;
        held_d = m_data; held_s = m_strb; held_l = m_last;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_strb = '0; s_last = 1'b0; m_ready = 1'b0;

    // Cycle-by-cycle vectors from reset. Expectations are the values seen in that
    // cycle before the rising edge. m_data is compared only on its strobed bytes.
    //          v     s_data        strb  last mr   srdy  wr_en  waddr ren   raddr mv    mstrb  ml    m_data                 lvl
    vt[0]  = '{1'b1, 32'h11111111, 4'hF, 1'b0, 1'b1, 1'b1, 8'h0F, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 64'h0,                 5'd0};
    vt[1]  = '{1'b1, 32'h22222222, 4'hF, 1'b1, 1'b1, 1'b1, 8'hF0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 64'h0,                 5'd0};
    vt[2]  = '{1'b1, 32'hAABBCCDD, 4'h3, 1'b1, 1'b1, 1'b1, 8'h03, 4'd1, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0, 64'h0,                 5'd1};
    vt[3]  = '{1'b1, 32'h55667788, 4'hF, 1'b0, 1'b1, 1'b1, 8'h0F, 4'd2, 1'b1, 4'd1, 1'b1, 8'hFF, 1'b1, 64'h2222222211111111, 5'd1};
    vt[4]  = '{1'b1, 32'h99AABBCC, 4'hC, 1'b1, 1'b1, 1'b1, 8'hC0, 4'd2, 1'b0, 4'd2, 1'b1, 8'h03, 1'b1, 64'h000000000000CCDD, 5'd0};
    vt[5]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd3, 1'b1, 4'd2, 1'b0, 8'h03, 1'b1, 64'h0,                 5'd1};
    vt[6]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd3, 1'b0, 4'd3, 1'b1, 8'hCF, 1'b1, 64'h99AA000055667788, 5'd0};
    vt[7]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd3, 1'b0, 4'd3, 1'b1, 8'hCF, 1'b1, 64'h99AA000055667788, 5'd0};
    vt[8]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd3, 1'b0, 4'd3, 1'b1, 8'hCF, 1'b1, 64'h99AA000055667788, 5'd0};
    vt[9]  = '{1'b1, 32'hDEADBEEF, 4'h0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd3, 1'b0, 4'd3, 1'b0, 8'hCF, 1'b1, 64'h0,                 5'd0};
    vt[10] = '{1'b1, 32'h12345678, 4'hF, 1'b1, 1'b1, 1'b1, 8'hF0, 4'd3, 1'b0, 4'd3, 1'b0, 8'hCF, 1'b1, 64'h0,                 5'd0};
    vt[11] = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd4, 1'b1, 4'd3, 1'b0, 8'hCF, 1'b1, 64'h0,                 5'd1};
    vt[12] = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd4, 1'b0, 4'd4, 1'b1, 8'hF0, 1'b1, 64'h1234567800000000, 5'd0};
    vt[13] = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd4, 1'b0, 4'd4, 1'b0, 8'hF0, 1'b1, 64'h0,                 5'd0};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_rd_en", 64'(ram_rd_en), 64'(0));
    chk("rst_wr_en", 64'(ram_wr_en), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_strb", 64'(m_strb), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Pack, partial last, zero-strobe beat, stall hold.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      s_valid = vt[i].s_valid; s_data = vt[i].s_data; s_strb = vt[i].s_strb;
      s_last = vt[i].s_last; m_ready = vt[i].m_ready;
      #1;
      chk($sformatf("row%0d s_ready", i), 64'(s_ready), 64'(vt[i].e_s_ready));
      chk($sformatf("row%0d wr_en", i), 64'(ram_wr_en), 64'(vt[i].e_wr_en));
      chk($sformatf("row%0d wr_addr", i), 64'(ram_wr_addr), 64'(vt[i].e_wr_addr));
      chk($sformatf("row%0d rd_en", i), 64'(ram_rd_en), 64'(vt[i].e_rd_en));
      chk($sformatf("row%0d rd_addr", i), 64'(ram_rd_addr), 64'(vt[i].e_rd_addr));
      chk($sformatf("row%0d m_valid", i), 64'(m_valid), 64'(vt[i].e_m_valid));
      chk($sformatf("row%0d m_strb", i), 64'(m_strb), 64'(vt[i].e_m_strb));
      chk($sformatf("row%0d m_last", i), 64'(m_last), 64'(vt[i].e_m_last));
      chk($sformatf("row%0d level", i), 64'(level), 64'(vt[i].e_level));
      if (vt[i].e_m_valid)
        chk($sformatf("row%0d m_data", i), m_data & strb_mask(vt[i].e_m_strb), vt[i].e_m_data);
    end
    @(negedge clk);
    s_valid = 1'b0;

    // Fill to full with m_ready low. Word 0 moves into the output register as soon
    // as it commits, so 16 words leave 15 in the buffer; a 17th word fills it.
    do_reset();
    sb_en = 1'b1;
    for (int w = 0; w < 16; w++) send_word(32'hA0000000 + 2*w, 32'hA0000001 + 2*w, 1'b0);
    @(negedge clk);
    #1;
    chk("fill16_level", 64'(level), 64'(15));
    chk("fill16_s_ready", 64'(s_ready), 64'(1));
    send_word(32'hA0000020, 32'hA0000021, 1'b1);
    @(negedge clk);
    #1;
    chk("full_level", 64'(level), 64'(16));
    chk("full_s_ready", 64'(s_ready), 64'(0));
    chk("full_m_valid", 64'(m_valid), 64'(1));
    chk("full_rd_en", 64'(ram_rd_en), 64'(0));
    base = hs_count;
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    chk("unfull_rd_en", 64'(ram_rd_en), 64'(1));
    chk("unfull_s_ready_same_cycle", 64'(s_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("unfull_s_ready_next", 64'(s_ready), 64'(1));
    repeat (16) @(negedge clk);
    #3;
    chk("drain_back_to_back", 64'(hs_count - base), 64'(17));
    chk("drain_m_valid_low", 64'(m_valid), 64'(0));
    chk("drain_queue", 64'(exp_q.size()), 64'(0));

    // Backpressure: m_ready toggles 1010 while 8 words stream in.
    base = hs_count;
    fork
      begin
        for (int w = 0; w < 8; w++)
          send_word(32'hB0000000 + 2*w, 32'hB0000001 + 2*w, (w == 7));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          m_ready = (c % 2 == 0);
        end
      end
    join
    drain(8, base);

    // Streaming with wrap: 40 words back-to-back.
    rdy_drops = 0;
    base = hs_count;
    for (int w = 0; w < 40; w++)
      send_word(32'hC0000000 + 2*w, 32'hC0000001 + 2*w, (w % 4 == 3));
    drain(40, base);
    chk("stream_s_ready_drops", 64'(rdy_drops), 64'(0));

    // Reset in the middle of a burst.
    sb_en = 1'b0;
    m_ready = 1'b0;
    send_beat(32'hD0000000, 4'hF, 1'b0);
    send_beat(32'hD0000001, 4'hF, 1'b0);
    send_beat(32'hD0000002, 4'hF, 1'b0);
    send_beat(32'hD0000003, 4'hF, 1'b0);
    send_beat(32'hD0000004, 4'hF, 1'b0);
    @(negedge clk);
    #1;
    chk("prerst_m_valid", 64'(m_valid), 64'(1));
    chk("prerst_level", 64'(level), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    chk("midrst_level", 64'(level), 64'(0));
    chk("midrst_s_ready", 64'(s_ready), 64'(1));
    chk("midrst_m_strb", 64'(m_strb), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;
    base = hs_count;
    exp_q.push_back('{last: 1'b1, data: 64'hE0000001E0000000});
    @(negedge clk);
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'hE0000000; s_strb = 4'hF; s_last = 1'b0;
    #1;
    chk("postrst_wr_en_lane0", 64'(ram_wr_en), 64'(8'h0F));
    chk("postrst_wr_addr", 64'(ram_wr_addr), 64'(0));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    send_beat(32'hE0000001, 4'hF, 1'b1);
    drain(1, base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
